seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive cycles seg_sel must stay stable before its digit is sampled.
REQ-002 SHALL have parameter TIMEOUT, default 20000: maximum cycles between seg_sel changes before the scan is declared lost.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this one clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port segment  input  8  active-low 7-segment pattern, {dp,g,f,e,d,c,b,a}.
REQ-006 SHALL have port seg_sel  input  6  one-cold digit select; bit k low selects digit k.
REQ-007 SHALL have port digit_data  output  24  last good frame, 6 BCD nibbles; digit k is in bits [4k+3:4k].
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when digit_data updates.
REQ-009 SHALL have port seg_err  output  1  one-cycle pulse when a sampled pattern is not a legal digit.
REQ-010 SHALL have port seq_err  output  1  one-cycle pulse on an out-of-order or non-one-cold select.
REQ-011 SHALL have port scan_lost  output  1  level, high while the scan is stalled.

Function
REQ-012 SHALL register segment and seg_sel once on input; all further logic uses the registered copies.
REQ-013 SHALL count stable cycles of registered seg_sel; the count restarts at 0 on any change.
REQ-014 SHALL sample a digit when a one-cold seg_sel has been stable for exactly SETTLE cycles; one sample per select period.
REQ-015 SHALL decode patterns, dp ignored: C0=0, F9=1, A4=2, B0=3, 99=4, 92=5, 82=6, F8=7, 80=8, 90=9; any other value is illegal.
REQ-016 SHALL run an FSM with states HUNT and COLLECT; reset state is HUNT, expected index 0.
REQ-017 SHALL in HUNT ignore every sample until digit 0 is sampled, then store that digit into a shadow register and go to COLLECT with expected index 1.
REQ-018 SHALL in COLLECT store a sample whose index equals the expected index, then increment the expected index.
REQ-019 SHALL on a COLLECT sample whose index is not the expected index pulse seq_err, discard the shadow and go to HUNT; if that index is 0 it re-enters COLLECT directly as in REQ-017.
REQ-020 SHALL treat a registered seg_sel that is not one-cold and is stable for SETTLE cycles as a sequence error in COLLECT and ignore it in HUNT.
REQ-021 SHALL on an illegal pattern pulse seg_err in the sample cycle and mark the frame bad.
REQ-022 SHALL, one cycle after the digit-5 sample of a good frame, load the shadow into digit_data and pulse frame_valid, then return to COLLECT with expected index 0 (no HUNT).
REQ-023 SHALL not update digit_data or pulse frame_valid for a bad frame; the frame-bad flag clears at the next digit-0 sample.
REQ-024 SHALL assert scan_lost and force HUNT when the stable count reaches TIMEOUT.
REQ-025 SHALL deassert scan_lost on the first subsequent seg_sel change.
REQ-026 SHALL never assert frame_valid, seg_err and seq_err in the same cycle for the same sample.
REQ-027 SHALL saturate the stable counter (16 bits) at TIMEOUT.

Reset
REQ-028 SHALL on reset drive digit_data=0, frame_valid=0, seg_err=0, seq_err=0, scan_lost=0, FSM=HUNT, expected index=0, all counters=0, input registers: segment=8'hFF, seg_sel=6'h3F.
REQ-029 SHALL, when reset asserts mid-frame, discard the partial shadow and emit no pulse after release until a complete new frame is captured.

Structure
REQ-030 SHALL take the ten digit pattern constants and the one-cold select constants from a shared package, seg_defs, which the display driver also uses.
REQ-031 SHALL use one combinational sub-module, seg_pattern_decode: 8-bit pattern in, 4-bit digit plus legal flag out.

Verification
REQ-032 SHALL check loopback from the team display driver with data 24'h123456 -> frame_valid within 140000 cycles and digit_data=24'h123456.
REQ-033 SHALL check a forced pattern 8'hFF on digit 2 -> one seg_err pulse, no frame_valid for that frame, digit_data unchanged.
REQ-034 SHALL check select order 0,1,3 -> seq_err in the digit-3 sample cycle, then recovery to a correct frame on the next full scan.
REQ-035 SHALL check seg_sel held at 6'b111101 -> scan_lost high after 20000 cycles, low on the next select change.
REQ-036 SHALL check a 2-cycle select glitch inside a digit period -> no sample, no error, frame still valid.
REQ-037 SHALL check reset pulsed during digit 3 -> outputs return to reset values, next frame_valid only after a full frame 0..5.

Source files
------------

// File: rtl/seg_defs.sv
// Shared 7-segment pattern and digit-select constants for the
// capture block and the display driver.
package seg_defs;

  localparam int unsigned NDIG = 6;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [5:0] SEL_0    = 6'b111110;
  localparam logic [5:0] SEL_1    = 6'b111101;
  localparam logic [5:0] SEL_2    = 6'b111011;
  localparam logic [5:0] SEL_3    = 6'b110111;
  localparam logic [5:0] SEL_4    = 6'b101111;
  localparam logic [5:0] SEL_5    = 6'b011111;
  localparam logic [5:0] SEL_NONE = 6'b111111;

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } sel_info_t;

  function automatic sel_info_t sel_decode(
    input logic [5:0] s
  );
    sel_info_t r;
    r.ok  = 1'b1;
    r.idx = 3'd0;
    unique case (1'b1)
      (s == SEL_0): r.idx = 3'd0;
      (s == SEL_1): r.idx = 3'd1;
      (s == SEL_2): r.idx = 3'd2;
      (s == SEL_3): r.idx = 3'd3;
      (s == SEL_4): r.idx = 3'd4;
      (s == SEL_5): r.idx = 3'd5;
      default:      r.ok  = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] digit_pattern(
    input logic [3:0] d
  );
    logic [7:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = 8'hFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Active-low 7-segment pattern to BCD digit; the decimal point
// is ignored.
module seg_pattern_decode
  import seg_defs::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  logic [7:0] p;

  assign p = pattern | 8'h80;

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (p)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Captures six-digit frames from a multiplexed 7-segment scan and
// reports decode, ordering and stall errors.
module seg_capture
  import seg_defs::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  segment,
  input  logic [5:0]  seg_sel,
  output logic [23:0] digit_data,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        seq_err,
  output logic        scan_lost
);

  localparam logic [15:0] ST_C = 16'(SETTLE);
  localparam logic [15:0] TO_C = 16'(TIMEOUT);

  logic [7:0]  seg_q;
  logic [5:0]  sel_q;
  logic [5:0]  sel_prev;
  logic [5:0]  last_sel;
  logic [15:0] cnt;
  state_t      state;
  logic [2:0]  exp_idx;
  logic [23:0] shadow;
  logic        bad;
  logic        commit;
  logic [3:0]  dig;
  logic        legal;
  sel_info_t   info;
  logic        chg;
  logic        smp;
  logic        lost_hit;
  logic        bad_next;
  logic [4:0]  pos;

  seg_pattern_decode u_dec (
    .pattern (seg_q),
    .digit   (dig),
    .legal   (legal)
  );

  assign info     = sel_decode(sel_q);
  assign chg      = sel_q != sel_prev;
  assign lost_hit = !chg && (cnt == TO_C - 16'd1);
  assign pos      = {info.idx, 2'b00};
  assign bad_next = (info.idx == 3'd0) ? !legal
                                       : (bad | !legal);

  // A select that glitches away and returns is the same period,
  // so it must not be sampled twice.
  assign smp = !chg && (cnt == ST_C - 16'd1)
             && (sel_q != last_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= 8'hFF;
      sel_q       <= SEL_NONE;
      sel_prev    <= SEL_NONE;
      last_sel    <= SEL_NONE;
      cnt         <= '0;
      state       <= HUNT;
      exp_idx     <= 3'd0;
      shadow      <= '0;
      bad         <= 1'b0;
      commit      <= 1'b0;
      digit_data  <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      seq_err     <= 1'b0;
      scan_lost   <= 1'b0;
    end else begin
      seg_q       <= segment;
      sel_q       <= seg_sel;
      sel_prev    <= sel_q;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      seq_err     <= 1'b0;

      if (chg) begin
        cnt <= '0;
      end else if (cnt != TO_C) begin
        cnt <= cnt + 16'd1;
      end

      if (chg) begin
        scan_lost <= 1'b0;
      end else if (lost_hit) begin
        scan_lost <= 1'b1;
      end

      if (commit) begin
        digit_data  <= shadow;
        frame_valid <= 1'b1;
        commit      <= 1'b0;
      end

      if (lost_hit) begin
        state    <= HUNT;
        exp_idx  <= 3'd0;
        bad      <= 1'b0;
        shadow   <= '0;
        last_sel <= SEL_NONE;
      end else if (smp) begin
        last_sel <= sel_q;
        case (state)
          HUNT: begin
            if (info.ok && info.idx == 3'd0) begin
              shadow  <= {20'd0, dig};
              bad     <= !legal;
              seg_err <= !legal;
              state   <= COLLECT;
              exp_idx <= 3'd1;
            end
          end
          COLLECT: begin
            if (!info.ok || info.idx != exp_idx) begin
              seq_err <= 1'b1;
              // Digit 0 out of turn starts a fresh frame at once.
              if (info.ok && info.idx == 3'd0) begin
                shadow  <= {20'd0, dig};
                bad     <= !legal;
                exp_idx <= 3'd1;
              end else begin
                state   <= HUNT;
                exp_idx <= 3'd0;
                shadow  <= '0;
              end
            end else begin
              shadow[pos +: 4] <= dig;
              seg_err          <= !legal;
              bad              <= bad_next;
              if (info.idx == 3'd5) begin
                exp_idx <= 3'd0;
                commit  <= !bad_next;
              end else begin
                exp_idx <= exp_idx + 3'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
